// File: rtl/aexm_memu_pkg.sv
// rtl/aexm_memu_pkg.sv - shared size codes, FSM encoding and timeout width for the load/store unit
package aexm_memu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  localparam int TMO_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } memState_t;

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    isMisaligned = ((size == SZ_HALF) && addrLo[0]) ||
                   ((size == SZ_WORD) && (addrLo != 2'b00));
  endfunction

endpackage

// File: rtl/aexm_lanes.sv
// rtl/aexm_lanes.sv - big-endian byte-lane steering: enables, store replication, load extraction
module aexm_lanes
  import aexm_memu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addrLo,
  input  logic [31:0] stDat,
  input  logic [3:0]  selReg,
  input  logic [31:0] busDat,
  output logic [3:0]  sel,
  output logic [31:0] stLanes,
  output logic [31:0] ldDat
);

  always_comb begin
    sel     = 4'h0;
    stLanes = 32'h0;
    case (size)
      SZ_BYTE: begin
        sel     = 4'b1000 >> addrLo;
        stLanes = {4{stDat[7:0]}};
      end
      SZ_HALF: begin
        sel     = addrLo[1] ? 4'h3 : 4'hC;
        stLanes = {2{stDat[15:0]}};
      end
      SZ_WORD: begin
        sel     = 4'hF;
        stLanes = stDat;
      end
      default: begin
        sel     = 4'h0;
        stLanes = 32'h0;
      end
    endcase
  end

  // Lane selection uses the enables latched at accept, so size need not be kept.
  always_comb begin
    ldDat = 32'h0;
    case (selReg)
      4'h8:    ldDat = {24'h0, busDat[31:24]};
      4'h4:    ldDat = {24'h0, busDat[23:16]};
      4'h2:    ldDat = {24'h0, busDat[15:8]};
      4'h1:    ldDat = {24'h0, busDat[7:0]};
      4'hC:    ldDat = {16'h0, busDat[31:16]};
      4'h3:    ldDat = {16'h0, busDat[15:0]};
      4'hF:    ldDat = busDat;
      default: ldDat = 32'h0;
    endcase
  end

endmodule

// File: rtl/aexm_memu.sv
// rtl/aexm_memu.sv - load/store unit: one data-bus cycle per access, pipeline stall, bus timeout
module aexm_memu
  import aexm_memu_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 30,
  parameter int TMO = 255
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          x_en,
  input  logic          xLD,
  input  logic          xST,
  input  logic [1:0]    xSIZE,
  input  logic [31:0]   xADDR,
  input  logic [DW-1:0] xSTDAT,
  output logic [AW-1:0] dwb_adr_o,
  output logic [DW-1:0] dwb_dat_o,
  output logic [3:0]    dwb_sel_o,
  output logic          dwb_stb_o,
  output logic          dwb_wre_o,
  input  logic          dwb_ack_i,
  input  logic [DW-1:0] dwb_dat_i,
  output logic          mem_stall,
  output logic [31:0]   rLDDAT,
  output logic          rLDVAL,
  output logic          rMISALIGN,
  output logic          rBUSERR
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);

  memState_t        state, nextState;
  logic [TMO_W-1:0] tmoCnt;
  logic             reqValid, reqMisal;
  logic             accept, misal, ackDone, tmoHit;
  logic [3:0]       laneSel;
  logic [31:0]      laneStDat;
  logic [31:0]      laneLdDat;

  aexm_lanes u_lanes (
    .size    (xSIZE),
    .addrLo  (xADDR[1:0]),
    .stDat   (xSTDAT),
    .selReg  (dwb_sel_o),
    .busDat  (dwb_dat_i),
    .sel     (laneSel),
    .stLanes (laneStDat),
    .ldDat   (laneLdDat)
  );

  assign reqValid  = x_en && (xLD || xST) && (xSIZE != SZ_RSVD);
  assign reqMisal  = isMisaligned(xSIZE, xADDR[1:0]);
  assign mem_stall = (state == ST_WAIT);

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    misal     = 1'b0;
    ackDone   = 1'b0;
    tmoHit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (reqValid) begin
          if (reqMisal) begin
            misal = 1'b1;
          end else begin
            accept    = 1'b1;
            nextState = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // An ack arriving on the timeout cycle still completes the access.
        if (dwb_ack_i) begin
          ackDone   = 1'b1;
          nextState = ST_IDLE;
        end else if (tmoCnt == TMO_LAST) begin
          tmoHit    = 1'b1;
          nextState = ST_IDLE;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      state     <= ST_IDLE;
      tmoCnt    <= '0;
      dwb_adr_o <= '0;
      dwb_dat_o <= '0;
      dwb_sel_o <= 4'h0;
      dwb_stb_o <= 1'b0;
      dwb_wre_o <= 1'b0;
      rLDDAT    <= 32'h0;
      rLDVAL    <= 1'b0;
      rMISALIGN <= 1'b0;
      rBUSERR   <= 1'b0;
    end else begin
      state     <= nextState;
      rLDVAL    <= 1'b0;
      rMISALIGN <= misal;
      rBUSERR   <= tmoHit;
      if (state == ST_WAIT) begin
        tmoCnt <= tmoCnt + 1'b1;
      end
      if (accept) begin
        dwb_adr_o <= xADDR[31:2];
        dwb_sel_o <= laneSel;
        dwb_dat_o <= laneStDat;
        dwb_wre_o <= xST;
        dwb_stb_o <= 1'b1;
        tmoCnt    <= '0;
      end
      if (ackDone) begin
        dwb_stb_o <= 1'b0;
        dwb_wre_o <= 1'b0;
        if (!dwb_wre_o) begin
          rLDDAT <= laneLdDat;
          rLDVAL <= 1'b1;
        end
      end
      if (tmoHit) begin
        dwb_stb_o <= 1'b0;
      end
    end
  end

endmodule
